// File: rtl/phy_rx_pkg.sv
// Shared constants for the PHY framing link: K-characters, FSM state codes
// and the MSB-aligned keep encoding used by both rx and tx sides.
package phy_rx_pkg;

    localparam logic [7:0] K_SOF   = 8'hFB;
    localparam logic [7:0] K_EOF   = 8'hFD;
    localparam logic [7:0] K_COMMA = 8'hBC;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DATA  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // Byte count to keep mask; the first byte always sits in the top lane.
    function automatic logic [3:0] keep_of(input logic [3:0] n);
        case (n)
            4'd0:    keep_of = 4'b0000;
            4'd1:    keep_of = 4'b1000;
            4'd2:    keep_of = 4'b1100;
            4'd3:    keep_of = 4'b1110;
            default: keep_of = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/phy_rx_lane_scan.sv
// Combinational scan of one rx word in lane order: locates the SOF, compacts
// payload bytes (first at [7:0]) and flags EOF or an unexpected K-char.
module phy_rx_lane_scan
    import phy_rx_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [3:0]  charisk_i,
    input  logic        in_frame_i,
    output logic        sof_found_o,
    output logic [1:0]  sof_lane_o,
    output logic [31:0] bytes_o,
    output logic [2:0]  cnt_o,
    output logic        eof_o,
    output logic        abort_o
);

    logic [3:0] is_sof;
    logic [3:0] is_eof;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign is_sof[gi] = charisk_i[gi] && (data_i[8*gi +: 8] == K_SOF);
        assign is_eof[gi] = charisk_i[gi] && (data_i[8*gi +: 8] == K_EOF);
    end

    logic active;
    logic done;

    always_comb begin
        sof_found_o = 1'b0;
        sof_lane_o  = 2'd0;
        bytes_o     = '0;
        cnt_o       = 3'd0;
        eof_o       = 1'b0;
        abort_o     = 1'b0;
        active      = in_frame_i;
        done        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!done) begin
                if (!active) begin
                    // Outside a frame only the SOF matters; commas and filler fall through.
                    if (is_sof[i]) begin
                        sof_found_o = 1'b1;
                        sof_lane_o  = 2'(i);
                        active      = 1'b1;
                    end
                end else if (!charisk_i[i]) begin
                    bytes_o[{cnt_o[1:0], 3'b000} +: 8] = data_i[8*i +: 8];
                    cnt_o = cnt_o + 3'd1;
                end else if (is_eof[i]) begin
                    eof_o = 1'b1;
                    done  = 1'b1;
                end else begin
                    abort_o = 1'b1;
                    done    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/phy_rx.sv
// Receive framing stage: strips idle/commas, packs payload into 32-bit
// MSB-first beats with keep/last, and flags aborted or dropped frames.
module phy_rx
    import phy_rx_pkg::*;
#(
    parameter int P_MAX_BYTES = 2048
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_gt_rx_done,
    input  logic [31:0] i_gt_rx_data,
    input  logic [3:0]  i_gt_rx_charisk,
    output logic        o_axi_m_valid,
    output logic [31:0] o_axi_m_data,
    output logic [3:0]  o_axi_m_keep,
    output logic        o_axi_m_last,
    output logic        o_rx_err
);

    localparam int CNT_W = $clog2(P_MAX_BYTES + 1);

    state_t             state_q, state_d;
    logic [63:0]        acc_q, acc_d;
    logic [3:0]         acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               drain_err_q, drain_err_d;
    logic               valid_q, valid_d;
    logic [31:0]        data_q, data_d;
    logic [3:0]         keep_q, keep_d;
    logic               last_q, last_d;
    logic               err_q, err_d;

    logic        sof_found;
    logic [1:0]  sof_lane;
    logic [31:0] scan_bytes;
    logic [2:0]  scan_cnt;
    logic        scan_eof;
    logic        scan_abort;

    phy_rx_lane_scan u_scan (
        .data_i      (i_gt_rx_data),
        .charisk_i   (i_gt_rx_charisk),
        .in_frame_i  (state_q == ST_DATA),
        .sof_found_o (sof_found),
        .sof_lane_o  (sof_lane),
        .bytes_o     (scan_bytes),
        .cnt_o       (scan_cnt),
        .eof_o       (scan_eof),
        .abort_o     (scan_abort)
    );

    // First four accumulator bytes as an output beat, unused lanes zeroed.
    function automatic logic [31:0] pack_beat(input logic [63:0] acc, input logic [3:0] n);
        logic [3:0] k;
        k = keep_of(n);
        pack_beat = {acc[7:0]   & {8{k[3]}}, acc[15:8]  & {8{k[2]}},
                     acc[23:16] & {8{k[1]}}, acc[31:24] & {8{k[0]}}};
    endfunction

    logic             frame_act;
    logic [3:0]       acc_base;
    logic [CNT_W-1:0] byte_base;
    logic [CNT_W-1:0] room;
    logic             lim_hit;
    logic [2:0]       take;
    logic [3:0]       total;
    logic [3:0]       pos;
    logic [63:0]      acc_n;
    logic             end_frame;
    logic             aborted;

    always_comb begin
        frame_act = (state_q == ST_DATA) || ((state_q == ST_IDLE) && sof_found);
        acc_base  = (state_q == ST_DATA) ? acc_cnt_q : 4'd0;
        byte_base = (state_q == ST_DATA) ? byte_cnt_q : '0;
        // Bytes past the length limit are discarded and the frame aborts there.
        room      = CNT_W'(P_MAX_BYTES) - byte_base;
        lim_hit   = room < CNT_W'(scan_cnt);
        take      = lim_hit ? room[2:0] : scan_cnt;
        total     = acc_base + {1'b0, take};
        aborted   = scan_abort || lim_hit;
        end_frame = frame_act && (scan_eof || aborted);
        acc_n     = (state_q == ST_DATA) ? acc_q : '0;
        pos       = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < take) begin
                pos = acc_base + 4'(i);
                acc_n[{pos[2:0], 3'b000} +: 8] = scan_bytes[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        drain_err_d = drain_err_q;
        valid_d     = 1'b0;
        data_d      = '0;
        keep_d      = '0;
        last_d      = 1'b0;
        err_d       = 1'b0;
        if (!i_gt_rx_done) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            acc_cnt_d   = 4'd0;
            byte_cnt_d  = '0;
            drain_err_d = 1'b0;
            err_d       = (state_q != ST_IDLE);
        end else if (state_q == ST_DRAIN) begin
            // A SOF arriving here breaks the inter-frame gap and is dropped.
            valid_d     = 1'b1;
            data_d      = pack_beat(acc_q, acc_cnt_q);
            keep_d      = keep_of(acc_cnt_q);
            last_d      = 1'b1;
            err_d       = drain_err_q || sof_found;
            state_d     = ST_IDLE;
            acc_d       = '0;
            acc_cnt_d   = 4'd0;
            byte_cnt_d  = '0;
            drain_err_d = 1'b0;
        end else if (frame_act) begin
            byte_cnt_d = byte_base + CNT_W'(take);
            if (end_frame && (total <= 4'd4)) begin
                valid_d    = (total != 4'd0);
                data_d     = pack_beat(acc_n, total);
                keep_d     = keep_of(total);
                last_d     = (total != 4'd0);
                err_d      = aborted;
                state_d    = ST_IDLE;
                acc_d      = '0;
                acc_cnt_d  = 4'd0;
                byte_cnt_d = '0;
            end else if (end_frame || (total >= 4'd5)) begin
                valid_d     = 1'b1;
                data_d      = pack_beat(acc_n, 4'd4);
                keep_d      = 4'b1111;
                acc_d       = {32'd0, acc_n[63:32]};
                acc_cnt_d   = total - 4'd4;
                state_d     = end_frame ? ST_DRAIN : ST_DATA;
                drain_err_d = end_frame && aborted;
            end else begin
                acc_d     = acc_n;
                acc_cnt_d = total;
                state_d   = ST_DATA;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            acc_cnt_q   <= 4'd0;
            byte_cnt_q  <= '0;
            drain_err_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            drain_err_q <= drain_err_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    assign o_axi_m_valid = valid_q;
    assign o_axi_m_data  = data_q;
    assign o_axi_m_keep  = keep_q;
    assign o_axi_m_last  = last_q;
    assign o_rx_err      = err_q;

endmodule

// File: tb/tb_phy_rx.sv
// Directed bench for phy_rx: each step drives one rx word and checks the
// registered beat {valid,data,keep,last,err} one edge later.
module tb_phy_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_done = 1'b1;
    logic [31:0] rx_data = 32'hBCBCBCBC;
    logic [3:0]  rx_k = 4'b1111;
    logic        m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        rx_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phy_rx #(.P_MAX_BYTES(8)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_gt_rx_done    (rx_done),
        .i_gt_rx_data    (rx_data),
        .i_gt_rx_charisk (rx_k),
        .o_axi_m_valid   (m_valid),
        .o_axi_m_data    (m_data),
        .o_axi_m_keep    (m_keep),
        .o_axi_m_last    (m_last),
        .o_rx_err        (rx_err)
    );

    // Expected beat layout: {valid, data[31:0], keep[3:0], last, err}
    localparam logic [38:0] NONE = 39'd0;
    localparam logic [38:0] ERR_ONLY = {1'b0, 32'd0, 4'b0000, 1'b0, 1'b1};

    function automatic logic [38:0] beat(input logic [31:0] d, input logic [3:0] k,
                                         input logic l, input logic e);
        beat = {1'b1, d, k, l, e};
    endfunction

    task automatic chk(input string tag, input logic [38:0] exp);
        logic [38:0] obs;
        obs = {m_valid, m_data, m_keep, m_last, rx_err};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed v=%0b d=%h k=%b l=%0b e=%0b expected v=%0b d=%h k=%b l=%0b e=%0b",
                   tag, obs[38], obs[37:6], obs[5:2], obs[1], obs[0],
                   exp[38], exp[37:6], exp[5:2], exp[1], exp[0]);
        end
        $display("check %-14s v=%0b d=%h k=%b l=%0b e=%0b", tag,
                 obs[38], obs[37:6], obs[5:2], obs[1], obs[0]);
    endtask

    task automatic step(input logic [31:0] d, input logic [3:0] k,
                        input string tag, input logic [38:0] exp);
        rx_data = d;
        rx_k    = k;
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    task automatic idle(input string tag, input logic [38:0] exp);
        step(32'hBCBCBCBC, 4'b1111, tag, exp);
    endtask

    initial begin
        #12;
        chk("reset", NONE);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle("idle0", NONE);

        // Two-beat frame with drain
        step(32'h332211FB, 4'b0001, "t1_sof", NONE);
        step(32'hFD665544, 4'b1000, "t1_beat0", beat(32'h11223344, 4'b1111, 1'b0, 1'b0));
        idle("t1_beat1", beat(32'h55660000, 4'b1100, 1'b1, 1'b0));
        idle("t1_gap", NONE);

        // Misaligned SOF
        step(32'h2211FB50, 4'b0010, "t2_sof", NONE);
        step(32'h0000FD33, 4'b0010, "t2_beat", beat(32'h11223300, 4'b1110, 1'b1, 1'b0));
        idle("t2_gap", NONE);

        // Exactly four bytes
        step(32'h332211FB, 4'b0001, "t3_sof", NONE);
        step(32'h0000FD44, 4'b0010, "t3_beat", beat(32'h11223344, 4'b1111, 1'b1, 1'b0));
        idle("t3_gap", NONE);

        // Abort on comma inside frame; trailing FD ignored
        step(32'h332211FB, 4'b0001, "t4_sof", NONE);
        step(32'h50BC50BC, 4'b0101, "t4_abort", beat(32'h11223300, 4'b1110, 1'b1, 1'b1));
        step(32'h000000FD, 4'b0001, "t4_fd_ign", NONE);
        idle("t4_gap", NONE);

        // Length limit of 8 bytes
        step(32'h332211FB, 4'b0001, "t5_sof", NONE);
        step(32'h77665544, 4'b0000, "t5_beat0", beat(32'h11223344, 4'b1111, 1'b0, 1'b0));
        step(32'hBBAA9988, 4'b0000, "t5_beat1", beat(32'h55667788, 4'b1111, 1'b1, 1'b1));
        step(32'h000000FD, 4'b0001, "t5_fd_ign", NONE);
        idle("t5_gap", NONE);

        // Empty frames: clean EOF is silent, abort pulses err alone
        step(32'h0000FDFB, 4'b0011, "empty_eof", NONE);
        idle("empty_gap", NONE);
        step(32'h0000BCFB, 4'b0011, "empty_abort", ERR_ONLY);
        idle("empty_gap2", NONE);

        // SOF arriving during drain is dropped with an error
        step(32'h332211FB, 4'b0001, "t6_sof", NONE);
        step(32'hFD665544, 4'b1000, "t6_beat0", beat(32'h11223344, 4'b1111, 1'b0, 1'b0));
        step(32'h443322FB, 4'b0001, "t6_drain_sof", beat(32'h55660000, 4'b1100, 1'b1, 1'b1));
        step(32'h0000FD55, 4'b0010, "t6_no_frame", NONE);
        idle("t6_gap", NONE);

        // Link drop mid-frame, then recovery
        step(32'h332211FB, 4'b0001, "t7_sof", NONE);
        rx_done = 1'b0;
        step(32'h00000044, 4'b0000, "t7_drop", ERR_ONLY);
        rx_done = 1'b1;
        idle("t7_gap", NONE);
        step(32'hDDCCBBFB, 4'b0001, "t7_sof2", NONE);
        step(32'h0000FDEE, 4'b0010, "t7_beat", beat(32'hBBCCDDEE, 4'b1111, 1'b1, 1'b0));
        idle("t7_gap2", NONE);

        // Asynchronous reset mid-frame clears outputs at once
        step(32'h332211FB, 4'b0001, "t8_sof", NONE);
        step(32'h77665544, 4'b0000, "t8_beat0", beat(32'h11223344, 4'b1111, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_rst", NONE);
        #3;
        rst_n = 1'b1;
        step(32'h332211FB, 4'b0001, "t8_sof2", NONE);
        step(32'h0000FD44, 4'b0010, "t8_beat", beat(32'h11223344, 4'b1111, 1'b1, 1'b0));
        idle("t8_gap", NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
